// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing, one-cycle-latency program-memory
// reads and a 2-entry {pc, instr} buffer toward the datapath.
// Optional HALT detection is enabled by defining FETCH_HALT_DETECT_EN.
module instr_fetch_unit #(
    parameter int         RAM_WIDTH     = 32,
    parameter int         RAM_ADDR_BITS = 9,
    parameter logic [4:0] HALT_OPCODE   = 5'd31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic                     imem_en,
    output logic [RAM_ADDR_BITS-1:0] imem_addr,
    input  logic [RAM_WIDTH-1:0]     imem_rdata,
    input  logic                     branch_valid,
    input  logic [RAM_ADDR_BITS-1:0] branch_target,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [RAM_WIDTH-1:0]     instr_out,
    output logic [RAM_ADDR_BITS-1:0] instr_pc,
    output logic                     halted
);

    logic [RAM_ADDR_BITS-1:0] pc;
    logic [RAM_ADDR_BITS-1:0] pc_mem [2];
    logic [RAM_WIDTH-1:0]     instr_mem [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;
    logic                     vld_p0;
    logic [RAM_ADDR_BITS-1:0] pc_p0;
    logic                     pop;
    logic                     push;
    logic                     is_run;
    logic                     halt_go;
    logic [2:0]               occupancy;

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state;

    assign is_run  = (state == RUN);
    assign halt_go = pop && (instr_out[31:27] == HALT_OPCODE);
    assign halted  = (state == HALT) && !reset;
`else
    logic unused_halt_opcode;

    // No HALT state in this build: the opcode is just data.
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign is_run  = 1'b1;
    assign halt_go = 1'b0;
    assign halted  = 1'b0;
`endif

    assign instr_valid = (count != 2'd0) && !reset;
    assign instr_out   = instr_valid ? instr_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;
    assign pop         = instr_valid && instr_ready;

    // An in-flight read is dropped by a branch or by entering HALT.
    assign push = vld_p0 && !branch_valid && is_run;

    // Buffered plus in-flight entries; a pop this cycle frees one slot.
    assign occupancy = {1'b0, count} + {2'b00, vld_p0};
    assign imem_en   = !reset && is_run && fetch_en && !branch_valid &&
                       (occupancy < (3'd2 + {2'b00, pop}));
    assign imem_addr = pc;

    // Control state: PC, buffer pointers/count, in-flight flag and run state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            vld_p0 <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            state  <= RUN;
`endif
        end else if (branch_valid) begin
            pc     <= branch_target;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            vld_p0 <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            state  <= RUN;
`endif
        end else if (halt_go) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            vld_p0 <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            state  <= HALT;
`endif
        end else begin
            vld_p0 <= imem_en;
            if (imem_en)
                pc <= pc + 1'b1;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // ---- stage p0: issued read address; buffer write on data return ----
    always_ff @(posedge clk) begin
        if (imem_en)
            pc_p0 <= pc;
        if (push) begin
            pc_mem[wr_ptr]    <= pc_p0;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RAM_WIDTH, default 32, instruction word width.
REQ-002 Parameter RAM_ADDR_BITS, default 9, program-memory address width and PC width.
REQ-003 Parameter HALT_OPCODE, default 5'd31, opcode value in instr[31:27] that marks a HALT instruction.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_en  input  1  high permits new program-memory reads.
REQ-007 imem_en  output  1  read strobe to the program memory; high for exactly the cycles a read is issued.
REQ-008 imem_addr  output  RAM_ADDR_BITS  read address; equals the current PC.
REQ-009 imem_rdata  input  RAM_WIDTH  program-memory data, valid one cycle after imem_en.
REQ-010 branch_valid  input  1  one-cycle redirect request.
REQ-011 branch_target  input  RAM_ADDR_BITS  redirect PC, sampled when branch_valid is high.
REQ-012 instr_valid  output  1  instr_out and instr_pc hold a valid instruction.
REQ-013 instr_ready  input  1  downstream datapath accepts the instruction this cycle.
REQ-014 instr_out  output  RAM_WIDTH  instruction at the buffer head.
REQ-015 instr_pc  output  RAM_ADDR_BITS  address the instruction was fetched from.
REQ-016 halted  output  1  high while the unit is in the HALT state.

Function
REQ-017 The unit SHALL contain a 2-entry FIFO of {pc, instr}; instr_valid = (count != 0), and instr_out/instr_pc SHALL come from the head entry.
REQ-018 A transfer SHALL occur when instr_valid && instr_ready; it pops the head entry.
REQ-019 A read SHALL be issued (imem_en=1) only when state is RUN, fetch_en=1, branch_valid=0 and count + in_flight - pop < 2, where in_flight is 1 if a read was issued last cycle and not squashed; this keeps the FIFO from overflowing.
REQ-020 On each issued read, the PC SHALL increment by 1 modulo 2^RAM_ADDR_BITS; all-ones SHALL wrap to 0.
REQ-021 Read data SHALL be pushed into the FIFO in the cycle after issue, tagged with the issuing PC; latency from imem_en to instr_valid SHALL be 2 cycles.
REQ-022 A simultaneous push and pop SHALL leave count unchanged with correct ordering.
REQ-023 branch_valid SHALL have priority over all other events: the FIFO is flushed, any in-flight read is squashed and never pushed, the PC is loaded with branch_target, and no read is issued that cycle; the first post-branch read issues the next cycle.
REQ-024 A pop in the same cycle as branch_valid SHALL still count as accepted by downstream; the remaining entries SHALL be discarded.
REQ-025 fetch_en=0 SHALL only stop new reads; in-flight data SHALL still be pushed and the FIFO SHALL keep draining.
REQ-026 States: RUN and HALT. RUN->HALT is defined under Configuration. HALT->RUN occurs on branch_valid. Reset forces RUN.

Reset
REQ-027 With reset high: PC=0, FIFO count=0, in_flight=0, state=RUN, instr_valid=0, imem_en=0, halted=0; instr_out and instr_pc read 0.
REQ-028 Reset asserted mid-operation SHALL discard buffered and in-flight data; the first read after reset deasserts SHALL be at address 0.

Configuration
REQ-029 With macro FETCH_HALT_DETECT_EN defined, a transfer whose instr[31:27]==HALT_OPCODE SHALL move the state to HALT on the next edge. In HALT: flush the FIFO, squash any in-flight read, issue no reads, and hold halted=1.
REQ-030 Without FETCH_HALT_DETECT_EN, HALT_OPCODE instructions SHALL pass through as ordinary instructions, the HALT state SHALL not exist, and halted SHALL be tied to 0.

Verification
REQ-031 Reset, fetch_en=1, instr_ready=1, memory word i = i -> imem_addr 0,1,2,... on consecutive cycles; instr_valid first high 2 cycles after the first imem_en; instr_pc/instr_out = 0,1,2,... with no gaps.
REQ-032 instr_ready=0 for 6 cycles while streaming -> exactly 2 entries are held, imem_en is low once the FIFO is full, and nothing is lost or duplicated after ready returns.
REQ-033 branch_valid with target 9'h100 while a read is in flight -> the squashed word never appears; the next delivered instr_pc is 0x100, then 0x101.
REQ-034 Start at PC 9'h1FE with ready=1 -> delivered instr_pc sequence is 0x1FE, 0x1FF, 0x000.
REQ-035 With FETCH_HALT_DETECT_EN, word 3 = {5'd31, 27'd0} -> after pc 3 is accepted, halted=1, imem_en stays 0, and instr_valid=0; branch_valid with target 0 -> fetching resumes at 0. Without the macro -> pc 4 follows normally and halted stays 0.
REQ-036 Reset asserted for 1 cycle with 2 entries buffered -> next cycle instr_valid=0; the first issued imem_addr is 0.
